// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive stages.
// - uart_state_e : frame FSM encoding used by both directions
// - BITS_DEF, DVSR_W_DEF : default frame width and bit-period divisor width
// - START_BIT, STOP_BIT : 8N1 line levels for the framing bits
package uart_pkg;

  localparam int BITS_DEF   = 8;
  localparam int DVSR_W_DEF = 13;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_e;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line, followed by a
// falling-edge detector on the synchronized level.
// Ports:
//   clk, rst : system clock, asynchronous active-high reset
//   bit_in   : raw serial line (idle high)
//   rx_s     : synchronized line level (two cycles behind bit_in)
//   fall     : high for one cycle when rx_s goes 1 -> 0
module rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic bit_in,
  output logic rx_s,
  output logic fall
);

  logic s1, s2, s_prev;

  // All flops reset to the idle line level so that leaving reset never
  // looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      s_prev <= 1'b1;
    end else begin
      s1     <= bit_in;
      s2     <= s1;
      s_prev <= s2;
    end
  end

  assign rx_s = s2;
  assign fall = s_prev & ~s2;

endmodule

// File: rtl/data_receive.sv
// UART 8N1 receive stage: recovers frames from the serial line by mid-bit
// sampling and presents each byte in a one-entry holding register.
// Ports:
//   clk, rst    : system clock, asynchronous active-high reset
//   bit_in      : serial line, idle high, asynchronous to clk
//   dvsr        : clock cycles per bit minus 1 (>= 3), latched at start edge
//   rd_ack      : consumer pulse that empties the holding register
//   data_out    : received byte, valid while rx_full = 1
//   rx_full     : holding register contains an unread byte
//   frame_err   : one-cycle pulse, stop bit sampled low
//   overrun_err : one-cycle pulse, good frame lost because register was full
//   busy        : high whenever the FSM is not in IDLE
//   state_dbg   : current FSM state, for observation only
//
// Handshake: a byte is offered while rx_full = 1; rd_ack high for one cycle
// consumes it and rx_full drops on the next edge. rd_ack with rx_full = 0
// is ignored. If a good frame completes in the same cycle as rd_ack, the new
// byte is loaded, rx_full stays 1, and no overrun is reported.
module data_receive
  import uart_pkg::*;
#(
  parameter int BITS   = BITS_DEF,
  parameter int DVSR_W = DVSR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic              rd_ack,
  output logic [BITS-1:0]   data_out,
  output logic              rx_full,
  output logic              frame_err,
  output logic              overrun_err,
  output logic              busy,
  output uart_state_e       state_dbg
);

  localparam int BW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(BITS - 1);

  logic rx_s, fall;

  rx_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .bit_in (bit_in),
    .rx_s   (rx_s),
    .fall   (fall)
  );

  uart_state_e       state, state_n;
  logic [DVSR_W-1:0] cnt;
  logic [DVSR_W-1:0] dv_reg;
  logic [BW-1:0]     bit_cnt;
  logic [BITS-1:0]   shreg;

  logic cnt_clr, latch_dv, bits_clr, shift_en, stop_tick;
  logic stop_good, load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    cnt_clr   = 1'b0;
    latch_dv  = 1'b0;
    bits_clr  = 1'b0;
    shift_en  = 1'b0;
    stop_tick = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          state_n  = START;
          latch_dv = 1'b1;
          cnt_clr  = 1'b1;
        end
      end
      START: begin
        // Half a bit in: a line back high means the edge was a glitch.
        if (cnt == (dv_reg >> 1)) begin
          cnt_clr = 1'b1;
          if (rx_s == START_BIT) begin
            state_n  = DATA;
            bits_clr = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt == dv_reg) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) state_n = STOP;
        end
      end
      STOP: begin
        // Leave at mid-stop so a following start edge is never missed.
        if (cnt == dv_reg) begin
          cnt_clr   = 1'b1;
          stop_tick = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign stop_good = stop_tick && (rx_s == STOP_BIT);
  assign load      = stop_good && (!rx_full || rd_ack);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      dv_reg      <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      data_out    <= '0;
      rx_full     <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + DVSR_W'(1);
      if (latch_dv) dv_reg <= dvsr;
      if (bits_clr)
        bit_cnt <= '0;
      else if (shift_en && bit_cnt != LAST_BIT)
        bit_cnt <= bit_cnt + BW'(1);
      // LSB arrives first, so shift right and enter at the top.
      if (shift_en) shreg <= {rx_s, shreg[BITS-1:1]};
      frame_err   <= stop_tick && (rx_s != STOP_BIT);
      overrun_err <= stop_good && rx_full && !rd_ack;
      if (load) begin
        data_out <= shreg;
        rx_full  <= 1'b1;
      end else if (rd_ack) begin
        rx_full <= 1'b0;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_data_receive.sv
module tb_data_receive;
  import uart_pkg::*;

  localparam int BITS = 8;
  localparam int DW   = 13;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rst;
  logic            bit_in;
  logic [DW-1:0]   dvsr;
  logic            rd_ack;
  logic [BITS-1:0] data_out;
  logic            rx_full, frame_err, overrun_err, busy;
  uart_state_e     state_dbg;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  data_receive #(.BITS(BITS), .DVSR_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bit_in      (bit_in),
    .dvsr        (dvsr),
    .rd_ack      (rd_ack),
    .data_out    (data_out),
    .rx_full     (rx_full),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Byte-level view of the receiver: a holding register and error tallies.
  logic [BITS-1:0] exp_q[$];
  logic            m_full = 1'b0;
  logic [BITS-1:0] m_data = '0;
  int              m_fe = 0;
  int              m_ov = 0;

  task automatic model_frame(input logic [BITS-1:0] b, input bit stop_ok, input bit ack);
    if (ack) m_full = 1'b0;
    if (stop_ok) begin
      if (!m_full) begin
        m_full = 1'b1;
        m_data = b;
        exp_q.push_back(b);
      end else begin
        m_ov++;
      end
    end else begin
      m_fe++;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int   fe_hi = 0, fe_rise = 0, ov_hi = 0, ov_rise = 0, excl = 0;
  logic prev_full = 1'b0, prev_fe = 1'b0, prev_ov = 1'b0;
  bit   busy_seen = 1'b0;
  int   full_cyc = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_full = 1'b0;
      prev_fe   = 1'b0;
      prev_ov   = 1'b0;
    end else begin
      if (frame_err) fe_hi++;
      if (frame_err && !prev_fe) fe_rise++;
      if (overrun_err) ov_hi++;
      if (overrun_err && !prev_ov) ov_rise++;
      if (frame_err && overrun_err) excl++;
      if (busy) busy_seen = 1'b1;
      if (rx_full && !prev_full) begin
        full_cyc = cyc;
        if (exp_q.size() == 0) check("unexpected_load", 32'd1, 32'd0);
        else                   check("load_data", 32'(data_out), 32'(exp_q.pop_front()));
      end
      prev_full = rx_full;
      prev_fe   = frame_err;
      prev_ov   = overrun_err;
    end
  end

  // ---------------- driver tasks ----------------
  int fall_cyc = 0;

  // One bit period on the line; optional ack on its first cycle and a
  // scrambled dvsr mid-bit (the receiver must be using its latched copy).
  task automatic drive_bit(input logic v, input int dv, input bit ack, input bit scramble);
    bit_in = v;
    for (int i = 0; i <= dv; i++) begin
      rd_ack = ack && (i == 0);
      if (scramble && i == 4) dvsr = DW'($urandom);
      @(negedge clk);
    end
    rd_ack = 1'b0;
  endtask

  task automatic send_frame(input logic [BITS-1:0] b, input bit stop_ok, input bit ack, input int dv);
    logic [BITS-1:0] v;
    v = b;
    dvsr = DW'(dv);
    model_frame(b, stop_ok, ack);
    fall_cyc = cyc;
    drive_bit(START_BIT, dv, ack, 1'b1);
    for (int k = 0; k < BITS; k++) drive_bit(v[k], dv, 1'b0, 1'b0);
    drive_bit(stop_ok ? STOP_BIT : 1'b0, dv, 1'b0, 1'b0);
    bit_in = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_rx_full"}, 32'(rx_full), 32'(m_full));
    check({tag, "_data"}, 32'(data_out), 32'(m_data));
    check({tag, "_frame_errs"}, 32'(fe_rise), 32'(m_fe));
    check({tag, "_overruns"}, 32'(ov_rise), 32'(m_ov));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, d, dv, n, gap;
    rst = 1'b1; bit_in = 1'b1; rd_ack = 1'b0; dvsr = DW'(15);
    idle(3);
    rst = 1'b0;
    idle(2);
    check("reset_data", 32'(data_out), 32'd0);
    check("reset_full", 32'(rx_full), 32'd0);
    check("reset_fe", 32'(frame_err), 32'd0);
    check("reset_ov", 32'(overrun_err), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    // Single frame, 16 cycles per bit, with latency window.
    send_frame(8'hA5, 1'b1, 1'b0, 15);
    lat = 2 + (15 >> 1) + 1 + (BITS + 1) * 16;
    d = full_cyc - fall_cyc;
    check("latency_window", 32'((d >= lat - 1) && (d <= lat + 1)), 32'd1);
    idle(20);
    check_state("a5");

    // Back-to-back frames, each acking the byte before it.
    send_frame(8'h3C, 1'b1, 1'b1, 15);
    send_frame(8'hC3, 1'b1, 1'b1, 15);
    idle(20);
    check_state("b2b");

    // Overrun: second frame arrives with the first unread.
    send_frame(8'h11, 1'b1, 1'b1, 15);
    send_frame(8'h22, 1'b1, 1'b0, 15);
    idle(20);
    check_state("overrun");

    // Framing error, then recovery.
    send_frame(8'h55, 1'b0, 1'b1, 15);
    idle(20);
    check_state("frame_err");
    send_frame(8'h0F, 1'b1, 1'b0, 15);
    idle(20);
    check_state("recover");

    // Short glitch must abort at the half-bit check.
    dvsr = DW'(15);
    busy_seen = 1'b0;
    bit_in = 1'b0;
    idle(3);
    bit_in = 1'b1;
    idle(40);
    check("glitch_busy_seen", 32'(busy_seen), 32'd1);
    check_state("glitch");

    // Break: line held low for many bit times -> one frame error only.
    dvsr = DW'(15);
    rd_ack = 1'b1; idle(1); rd_ack = 1'b0;
    m_full = 1'b0;
    m_fe++;
    bit_in = 1'b0;
    idle(16 * 14);
    check("break_full", 32'(rx_full), 32'd0);
    check("break_frame_errs", 32'(fe_rise), 32'(m_fe));
    bit_in = 1'b1;
    idle(40);
    check_state("break");
    send_frame(8'h5A, 1'b1, 1'b0, 15);
    idle(20);
    check_state("after_break");

    // Reset during bit 4 of a frame.
    dvsr = DW'(15);
    bit_in = 1'b0;
    idle(16 * 5 + 6);
    #2 rst = 1'b1;
    #1;
    check("midrst_data", 32'(data_out), 32'd0);
    check("midrst_full", 32'(rx_full), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    m_full = 1'b0; m_data = '0; exp_q.delete();
    @(negedge clk);
    bit_in = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(5);
    send_frame(8'hFF, 1'b1, 1'b0, 15);
    idle(20);
    check_state("post_reset");

    // Randomized batches.
    for (int bt = 0; bt < 6; bt++) begin
      dv = $urandom_range(9, 24);
      n  = $urandom_range(2, 5);
      for (int f = 0; f < n; f++) begin
        send_frame(BITS'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, dv);
        gap = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 20);
        idle(gap);
      end
      idle(2 * (dv + 1));
      check_state("random");
    end

    check("frame_err_width", 32'(fe_hi), 32'(fe_rise));
    check("overrun_width", 32'(ov_hi), 32'(ov_rise));
    check("errors_exclusive", 32'(excl), 32'd0);
    check("loads_pending", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
